// File: rtl/enco_pkg.sv
// Shared constants and helpers for the 16-to-4 encoder and its matching decoder.
// Provides IN_N, CODE_W and the onehot_ok popcount check.
package enco_pkg;

  localparam int IN_N   = 16;
  localparam int CODE_W = 4;

  // True when at most one bit is set: clearing the lowest set bit leaves nothing.
  function automatic logic onehot_ok(input logic [IN_N-1:0] v);
    logic [IN_N-1:0] low_cleared;
    low_cleared = v & (v - 1'b1);
    return (low_cleared == '0);
  endfunction

endpackage

// File: rtl/enco_prio16.sv
// Combinational 16-bit highest-index priority encoder.
// Built as a binary halving tree: each code bit picks the upper or lower half.
module enco_prio16
  import enco_pkg::*;
(
  input  logic [IN_N-1:0]   vec,
  output logic [CODE_W-1:0] code,
  output logic              any_hi
);

  logic [7:0] half8;
  logic [3:0] half4;
  logic [1:0] half2;

  always_comb begin
    code    = '0;
    code[3] = |vec[15:8];
    half8   = code[3] ? vec[15:8] : vec[7:0];
    code[2] = |half8[7:4];
    half4   = code[2] ? half8[7:4] : half8[3:0];
    code[1] = |half4[3:2];
    half2   = code[1] ? half4[3:2] : half4[1:0];
    code[0] = half2[1];
    any_hi  = |vec;
  end

endmodule

// File: rtl/enco_16x4_reg.sv
// Registered 16-to-4 encoder, one cycle latency, highest index wins.
// Define ENCO_ONEHOT_CHECK_EN to register a multi-hot flag on err.
module enco_16x4_reg
  import enco_pkg::*;
#(
  parameter logic [CODE_W-1:0] RESET_CODE = 4'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  input  logic x6,
  input  logic x7,
  input  logic x8,
  input  logic x9,
  input  logic x10,
  input  logic x11,
  input  logic x12,
  input  logic x13,
  input  logic x14,
  input  logic x15,
  output logic s3,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic valid,
  output logic err
);

  logic [IN_N-1:0]   req_vec;
  logic [CODE_W-1:0] prio_code;
  logic              prio_any;

  logic [CODE_W-1:0] code_d, code_q;
  logic              valid_d, valid_q;

  assign req_vec = {x15, x14, x13, x12,
                    x11, x10, x9,  x8,
                    x7,  x6,  x5,  x4,
                    x3,  x2,  x1,  x0};

  enco_prio16 u_prio (
    .vec    (req_vec),
    .code   (prio_code),
    .any_hi (prio_any)
  );

  always_comb begin
    code_d  = RESET_CODE;
    valid_d = 1'b0;
    if (rst) begin
      code_d  = RESET_CODE;
      valid_d = 1'b0;
    end else if (prio_any) begin
      code_d  = prio_code;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    code_q  <= code_d;
    valid_q <= valid_d;
  end

  assign {s3, s2, s1, s0} = code_q;
  assign valid            = valid_q;

`ifdef ENCO_ONEHOT_CHECK_EN
  logic err_d, err_q;

  always_comb begin
    err_d = 1'b0;
    if (!rst) err_d = ~onehot_ok(req_vec);
  end

  always_ff @(posedge clk) begin
    err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_enco_16x4_reg.sv
// Self-checking bench for enco_16x4_reg: directed scenarios plus random
// vectors compared every cycle against a behavioural model.
module tb_enco_16x4_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] xv  = '0;
  logic        s3, s2, s1, s0, valid, err;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_code  = '0;
  logic       exp_valid = 1'b0;
  logic       exp_err   = 1'b0;
  bit         have_exp  = 1'b0;

  always #5 clk = ~clk;

  enco_16x4_reg #(.RESET_CODE(4'd0)) dut (
    .clk(clk), .rst(rst),
    .x0(xv[0]),   .x1(xv[1]),   .x2(xv[2]),   .x3(xv[3]),
    .x4(xv[4]),   .x5(xv[5]),   .x6(xv[6]),   .x7(xv[7]),
    .x8(xv[8]),   .x9(xv[9]),   .x10(xv[10]), .x11(xv[11]),
    .x12(xv[12]), .x13(xv[13]), .x14(xv[14]), .x15(xv[15]),
    .s3(s3), .s2(s2), .s1(s1), .s0(s0),
    .valid(valid), .err(err)
  );

  // Model: what each edge must produce, from the inputs it saw.
  always @(posedge clk) begin
    int cnt;
    int top;
    cnt = $countones(xv);
    top = -1;
    for (int i = 0; i < 16; i++)
      if (xv[i]) top = i;
    if (rst) begin
      exp_code  = 4'd0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end else begin
      exp_code  = (top < 0) ? 4'd0 : 4'(top);
      exp_valid = (cnt > 0);
`ifdef ENCO_ONEHOT_CHECK_EN
      exp_err   = (cnt >= 2);
`else
      exp_err   = 1'b0;
`endif
    end
    have_exp = 1'b1;
  end

  always @(negedge clk) begin
    if (have_exp) begin
      tests++;
      if ({s3, s2, s1, s0} !== exp_code || valid !== exp_valid
          || err !== exp_err) begin
        fails++;
        $display("FAIL model: got s=%0d v=%0b e=%0b want s=%0d v=%0b e=%0b",
                 {s3, s2, s1, s0}, valid, err, exp_code, exp_valid, exp_err);
      end
    end
  end

  task automatic drive(input logic [15:0] v, input logic r);
    xv  = v;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int es, input bit ev,
                           input bit ee);
    tests++;
    if ({s3, s2, s1, s0} !== 4'(es) || valid !== ev || err !== ee) begin
      fails++;
      $display("FAIL %s: got s=%0d v=%0b e=%0b want s=%0d v=%0b e=%0b",
               name, {s3, s2, s1, s0}, valid, err, es, ev, ee);
    end
  endtask

  bit mh;

  initial begin
`ifdef ENCO_ONEHOT_CHECK_EN
    mh = 1'b1;
`else
    mh = 1'b0;
`endif
    // Reset held with x5 high
    drive(16'h0020, 1'b1);
    drive(16'h0020, 1'b1);
    check_lit("reset", 0, 1'b0, 1'b0);
    drive(16'h0020, 1'b0);
    check_lit("release", 5, 1'b1, 1'b0);

    // One-hot walk
    for (int i = 0; i < 16; i++) begin
      drive(16'(1) << i, 1'b0);
      check_lit($sformatf("walk%0d", i), i, 1'b1, 1'b0);
    end

    // Idle versus x0
    drive(16'h0000, 1'b0);
    check_lit("idle", 0, 1'b0, 1'b0);
    drive(16'h0001, 1'b0);
    check_lit("x0_only", 0, 1'b1, 1'b0);

    // Multi-hot
    drive(16'h0208, 1'b0);
    check_lit("x3_x9", 9, 1'b1, mh);
    drive(16'hFFFF, 1'b0);
    check_lit("all_hi", 15, 1'b1, mh);

    // Mid-stream reset with x12 held
    drive(16'h1000, 1'b0);
    check_lit("x12", 12, 1'b1, 1'b0);
    drive(16'h1000, 1'b1);
    check_lit("mid_rst", 0, 1'b0, 1'b0);
    drive(16'h1000, 1'b0);
    check_lit("after_rst", 12, 1'b1, 1'b0);

    // Output must not follow inputs between edges
    drive(16'h0080, 1'b0);
    check_lit("x7", 7, 1'b1, 1'b0);
    xv = 16'h0100;
    #2;
    check_lit("hold_x7", 7, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_lit("x8", 8, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] v;
      logic        r;
      case ($urandom_range(0, 4))
        0: v = '0;
        1: v = 16'(1) << $urandom_range(0, 15);
        2: v = 16'hFFFF;
        default: v = 16'($urandom);
      endcase
      r = ($urandom_range(0, 19) == 0);
      drive(v, r);
    end

    drive(16'h0000, 1'b0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
